// File: rtl/ps2_pkg.sv
// Shared state encoding, protocol constants and error codes for the PS/2 host controller.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    TX_BITS,
    TX_ACK,
    WAIT_RESP
  } state_t;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NOACK   = 2'b10;
  localparam logic [1:0] ERR_RETRY   = 2'b11;

  // Odd-parity bit of a frame: 1 when the byte carries an even number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for an asynchronous line plus a registered falling-edge pulse.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic fall_o
);

  // [0] metastability stage, [1] synced level, [2] previous synced level
  logic [2:0] sync_q;
  logic       fall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 3'b111;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], d_i};
      fall_q <= sync_q[2] & ~sync_q[1];
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_ctrl.sv
// Host-side PS/2 command sequencer: inhibit, request-to-send, bit-serial transmit,
// line-ack check and keyboard reply handling, with unsolicited bytes forwarded as scan codes.
module ps2_host_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic       clock_fpga,
  input  logic       reset,
  input  logic       clock_key,
  input  logic       data_key,
  output logic       clock_key_oe,
  output logic       data_key_oe,
  output logic       rx_flush,
  input  logic [7:0] rx_code,
  input  logic       rx_new,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  output logic       cmd_ready,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [7:0] scan_code,
  output logic       scan_valid
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned IDX_W   = 4;

  state_t             state_q, state_d;
  logic               clk_oe_q, clk_oe_d;
  logic               dat_oe_q, dat_oe_d;
  logic               rx_flush_q, rx_flush_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [7:0]         scan_code_q, scan_code_d;
  logic               scan_valid_q, scan_valid_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [7:0]         arg_q, arg_d;
  logic               has_arg_q, has_arg_d;
  logic               byte_sel_q, byte_sel_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rx_new_q;
  logic [1:0]         dsync_q;

  logic       kfall;
  logic       data_s;
  logic       rx_rise;
  logic       timeout_hit;
  logic [7:0] tx_byte;

  ps2_sync_edge u_clk_sync (
    .clk    (clock_fpga),
    .reset  (reset),
    .d_i    (clock_key),
    .fall_o (kfall)
  );

  // Data line only needs a level synchroniser; it is sampled on kfall.
  always_ff @(posedge clock_fpga) begin
    if (reset) dsync_q <= 2'b11;
    else       dsync_q <= {dsync_q[0], data_key};
  end

  assign data_s      = dsync_q[1];
  assign rx_rise     = rx_new & ~rx_new_q;
  assign tx_byte     = byte_sel_q ? arg_q : cmd_q;
  assign timeout_hit = (state_q inside {REQ, TX_BITS, TX_ACK, WAIT_RESP}) &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock_fpga) begin
    if (reset) begin
      state_q      <= IDLE;
      clk_oe_q     <= 1'b0;
      dat_oe_q     <= 1'b0;
      rx_flush_q   <= 1'b0;
      cmd_ready_q  <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= ERR_NONE;
      scan_code_q  <= 8'h00;
      scan_valid_q <= 1'b0;
      cmd_q        <= 8'h00;
      arg_q        <= 8'h00;
      has_arg_q    <= 1'b0;
      byte_sel_q   <= 1'b0;
      retry_q      <= '0;
      bit_idx_q    <= '0;
      cnt_q        <= '0;
      rx_new_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_oe_q     <= clk_oe_d;
      dat_oe_q     <= dat_oe_d;
      rx_flush_q   <= rx_flush_d;
      cmd_ready_q  <= cmd_ready_d;
      done_q       <= done_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      cmd_q        <= cmd_d;
      arg_q        <= arg_d;
      has_arg_q    <= has_arg_d;
      byte_sel_q   <= byte_sel_d;
      retry_q      <= retry_d;
      bit_idx_q    <= bit_idx_d;
      cnt_q        <= cnt_d;
      rx_new_q     <= rx_new;
    end
  end

  always_comb begin
    state_d      = state_q;
    clk_oe_d     = clk_oe_q;
    dat_oe_d     = dat_oe_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    err_code_d   = err_code_q;
    scan_code_d  = scan_code_q;
    scan_valid_d = 1'b0;
    cmd_d        = cmd_q;
    arg_d        = arg_q;
    has_arg_d    = has_arg_q;
    byte_sel_d   = byte_sel_q;
    retry_d      = retry_q;
    bit_idx_d    = bit_idx_q;
    cnt_d        = cnt_q;

    if (timeout_hit) begin
      state_d    = IDLE;
      clk_oe_d   = 1'b0;
      dat_oe_d   = 1'b0;
      error_d    = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rx_rise) begin
            scan_code_d  = rx_code;
            scan_valid_d = 1'b1;
          end
          if (cmd_valid && cmd_ready_q) begin
            cmd_d      = cmd_byte;
            arg_d      = cmd_arg;
            has_arg_d  = cmd_has_arg;
            byte_sel_d = 1'b0;
            retry_d    = '0;
            cnt_d      = '0;
            clk_oe_d   = 1'b1;
            state_d    = INHIBIT;
          end
        end
        INHIBIT: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
            dat_oe_d = 1'b1;
            cnt_d    = '0;
            state_d  = REQ;
          end
        end
        REQ: begin
          clk_oe_d  = 1'b0;
          cnt_d     = cnt_q + CNT_W'(1);
          bit_idx_d = '0;
          state_d   = TX_BITS;
        end
        TX_BITS: begin
          cnt_d = cnt_q + CNT_W'(1);
          // Index 0..7 data, 8 parity, 9 stop (released); the next fall hands over to the ack.
          if (kfall) begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            if (bit_idx_q < IDX_W'(8))       dat_oe_d = ~tx_byte[bit_idx_q[2:0]];
            else if (bit_idx_q == IDX_W'(8)) dat_oe_d = ~odd_parity(tx_byte);
            else if (bit_idx_q == IDX_W'(9)) dat_oe_d = 1'b0;
            else                             state_d  = TX_ACK;
          end
        end
        TX_ACK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (kfall) begin
            dat_oe_d = 1'b0;
            if (!data_s) begin
              cnt_d   = '0;
              state_d = WAIT_RESP;
            end else begin
              error_d    = 1'b1;
              err_code_d = ERR_NOACK;
              state_d    = IDLE;
            end
          end
        end
        WAIT_RESP: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (rx_rise) begin
            if (rx_code == PS2_ACK) begin
              if (has_arg_q && !byte_sel_q) begin
                byte_sel_d = 1'b1;
                retry_d    = '0;
                cnt_d      = '0;
                clk_oe_d   = 1'b1;
                state_d    = INHIBIT;
              end else begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end else if (rx_code == PS2_RESEND) begin
              if (retry_q < RETRY_W'(MAX_RETRY)) begin
                retry_d  = retry_q + RETRY_W'(1);
                cnt_d    = '0;
                clk_oe_d = 1'b1;
                state_d  = INHIBIT;
              end else begin
                error_d    = 1'b1;
                err_code_d = ERR_RETRY;
                state_d    = IDLE;
              end
            end else begin
              scan_code_d  = rx_code;
              scan_valid_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    cmd_ready_d = (state_d == IDLE);
    rx_flush_d  = state_d inside {INHIBIT, REQ, TX_BITS, TX_ACK};
  end

  assign clock_key_oe = clk_oe_q;
  assign data_key_oe  = dat_oe_q;
  assign rx_flush     = rx_flush_q;
  assign cmd_ready    = cmd_ready_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_code_q;
  assign scan_code    = scan_code_q;
  assign scan_valid   = scan_valid_q;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Bench for ps2_host_ctrl: keyboard BFM on the open-drain lines, receiver stand-in on rx_*,
// and a scoreboard that matches done/error/scan pulses against queued expectations.
module tb_ps2_host_ctrl;

  localparam int unsigned INH = 20;
  localparam int unsigned TO  = 1500;
  localparam int unsigned MR  = 2;
  localparam int          HP  = 15;

  localparam int EV_DONE = 0;
  localparam int EV_ERR  = 1;
  localparam int EV_SCAN = 2;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       kbd_clk = 1'b1;
  logic       kbd_dat = 1'b1;
  logic [7:0] rx_code = 8'h00;
  logic       rx_new = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_byte = 8'h00;
  logic       cmd_has_arg = 1'b0;
  logic [7:0] cmd_arg = 8'h00;

  logic       clock_key, data_key;
  logic       clock_key_oe, data_key_oe, rx_flush, cmd_ready;
  logic       done, error, scan_valid;
  logic [1:0] err_code;
  logic [7:0] scan_code;

  ev_t        ev_q[$];
  logic [7:0] frame_q[$];
  int         checks = 0;
  int         failures = 0;
  int         tcount;

  assign clock_key = kbd_clk & ~clock_key_oe;
  assign data_key  = kbd_dat & ~data_key_oe;

  ps2_host_ctrl #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO),
    .MAX_RETRY      (MR)
  ) dut (
    .clock_fpga   (clk),
    .reset        (reset),
    .clock_key    (clock_key),
    .data_key     (data_key),
    .clock_key_oe (clock_key_oe),
    .data_key_oe  (data_key_oe),
    .rx_flush     (rx_flush),
    .rx_code      (rx_code),
    .rx_new       (rx_new),
    .cmd_valid    (cmd_valid),
    .cmd_byte     (cmd_byte),
    .cmd_has_arg  (cmd_has_arg),
    .cmd_arg      (cmd_arg),
    .cmd_ready    (cmd_ready),
    .done         (done),
    .error        (error),
    .err_code     (err_code),
    .scan_code    (scan_code),
    .scan_valid   (scan_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    ev_q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input logic [7:0] val);
    ev_t e;
    if (ev_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind=%0d val=0x%0h expected none", kind, val);
    end else begin
      e = ev_q.pop_front();
      chk("event_kind", 32'(kind), 32'(e.kind));
      chk("event_val", 32'(val), 32'(e.val));
    end
  endtask

  // Scoreboard monitor: every output pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (done)       pop_cmp(EV_DONE, 8'h00);
      if (error)      pop_cmp(EV_ERR, {6'b0, err_code});
      if (scan_valid) pop_cmp(EV_SCAN, scan_code);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] b, input logic has, input logic [7:0] a);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      failures++;
      $display("FAIL cmd_ready_wait: got 0 expected 1 within 5000 cycles");
    end
    cmd_valid   = 1'b1;
    cmd_byte    = b;
    cmd_has_arg = has;
    cmd_arg     = a;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Receiver stand-in: present a code with a multi-cycle new_code strobe.
  task automatic reply(input logic [7:0] code);
    cycles(10);
    rx_code = code;
    rx_new  = 1'b1;
    cycles(3);
    rx_new  = 1'b0;
    cycles(2);
  endtask

  // Keyboard side of a host-to-device frame; n_pulses < 12 models a stalled keyboard.
  task automatic host_frame(input bit ack, input int n_pulses);
    logic [9:0] bits;
    logic [7:0] b;
    logic [7:0] exp;
    int         n;
    int         ones;
    n = 0;
    while (!(data_key_oe === 1'b1 && clock_key_oe === 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL rts_wait: got no request-to-send expected one within 2000 cycles");
      return;
    end
    cycles(10);
    chk("start_bit", 32'(data_key), 32'd0);
    bits = '0;
    for (int i = 0; i < n_pulses; i++) begin
      if (i == 11 && ack) begin
        kbd_dat = 1'b0;
        cycles(4);
      end
      kbd_clk = 1'b0;
      cycles(HP);
      if (i < 10) bits[i] = data_key;
      kbd_clk = 1'b1;
      cycles(HP);
    end
    kbd_dat = 1'b1;
    if (n_pulses == 12) begin
      b    = bits[7:0];
      ones = 0;
      for (int k = 0; k < 8; k++) ones += int'(b[k]);
      if (frame_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame: got 0x%0h expected none", b);
      end else begin
        exp = frame_q.pop_front();
        chk("frame_byte", 32'(b), 32'(exp));
      end
      chk("frame_parity", 32'(bits[8]), (ones % 2 == 0) ? 32'd1 : 32'd0);
      chk("frame_stop", 32'(bits[9]), 32'd1);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      failures++;
      $display("FAIL idle_wait: got cmd_ready=0 expected 1 within 5000 cycles");
    end
    cycles(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    reset = 1'b1;
    cycles(3);
    chk("rst_clock_oe", 32'(clock_key_oe), 32'd0);
    chk("rst_data_oe", 32'(data_key_oe), 32'd0);
    chk("rst_rx_flush", 32'(rx_flush), 32'd0);
    chk("rst_pulses", {29'd0, done, error, scan_valid}, 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_scan_code", 32'(scan_code), 32'd0);
    reset = 1'b0;
    cycles(1);
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    // 1: two-byte command, both bytes acknowledged
    frame_q.push_back(8'hED);
    frame_q.push_back(8'h02);
    expect_ev(EV_DONE, 8'h00);
    send_cmd(8'hED, 1'b1, 8'h02);
    cycles(2);
    chk("inhibit_clock_oe", 32'(clock_key_oe), 32'd1);
    chk("inhibit_rx_flush", 32'(rx_flush), 32'd1);
    chk("inhibit_ready", 32'(cmd_ready), 32'd0);
    host_frame(1'b1, 12);
    chk("wait_resp_flush", 32'(rx_flush), 32'd0);
    reply(8'hFA);
    host_frame(1'b1, 12);
    reply(8'hFA);
    wait_idle();
    chk("t1_err_code", 32'(err_code), 32'd0);

    // 2a: two resends then acknowledge
    repeat (3) frame_q.push_back(8'hFF);
    expect_ev(EV_DONE, 8'h00);
    send_cmd(8'hFF, 1'b0, 8'h00);
    host_frame(1'b1, 12);
    reply(8'hFE);
    host_frame(1'b1, 12);
    reply(8'hFE);
    host_frame(1'b1, 12);
    reply(8'hFA);
    wait_idle();

    // 2b: retries exhausted
    repeat (3) frame_q.push_back(8'hFF);
    expect_ev(EV_ERR, 8'h03);
    send_cmd(8'hFF, 1'b0, 8'h00);
    for (int r = 0; r < 3; r++) begin
      host_frame(1'b1, 12);
      reply(8'hFE);
    end
    wait_idle();
    chk("t2b_err_code_hold", 32'(err_code), 32'd3);

    // 3: keyboard stalls after bit 4 -> timeout
    expect_ev(EV_ERR, 8'h01);
    send_cmd(8'hF4, 1'b0, 8'h00);
    fork
      host_frame(1'b1, 5);
      begin
        tcount = 0;
        while (clock_key_oe !== 1'b0 && tcount < 1000) begin
          @(negedge clk);
          tcount++;
        end
        tcount = 0;
        while (error !== 1'b1 && tcount < 2 * TO) begin
          @(negedge clk);
          tcount++;
        end
        chk("timeout_latency", 32'(tcount), 32'(TO - 1));
      end
    join
    cycles(2);
    chk("to_clock_oe", 32'(clock_key_oe), 32'd0);
    chk("to_data_oe", 32'(data_key_oe), 32'd0);
    chk("to_ready", 32'(cmd_ready), 32'd1);
    chk("to_rx_flush", 32'(rx_flush), 32'd0);

    // 4: no line-ack bit
    frame_q.push_back(8'hF4);
    expect_ev(EV_ERR, 8'h02);
    send_cmd(8'hF4, 1'b0, 8'h00);
    host_frame(1'b0, 12);
    wait_idle();

    // 5: unsolicited bytes while idle, then one during a reply wait
    expect_ev(EV_SCAN, 8'h1C);
    expect_ev(EV_SCAN, 8'hF0);
    expect_ev(EV_SCAN, 8'h1C);
    reply(8'h1C);
    reply(8'hF0);
    reply(8'h1C);
    chk("scan_code_hold", 32'(scan_code), 32'h1C);
    frame_q.push_back(8'hEE);
    expect_ev(EV_SCAN, 8'h1C);
    expect_ev(EV_DONE, 8'h00);
    send_cmd(8'hEE, 1'b0, 8'h00);
    host_frame(1'b1, 12);
    reply(8'h1C);
    chk("wait_continues", 32'(cmd_ready), 32'd0);
    reply(8'hFA);
    wait_idle();

    // 6: reset in the middle of a transmit, then a clean command
    send_cmd(8'hF3, 1'b1, 8'h20);
    host_frame(1'b1, 6);
    cycles(2);
    chk("mid_tx_flush", 32'(rx_flush), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_clock_oe", 32'(clock_key_oe), 32'd0);
    chk("mid_rst_data_oe", 32'(data_key_oe), 32'd0);
    chk("mid_rst_rx_flush", 32'(rx_flush), 32'd0);
    chk("mid_rst_pulses", {30'd0, done, error}, 32'd0);
    reset = 1'b0;
    cycles(1);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    cycles(50);
    frame_q.push_back(8'hED);
    frame_q.push_back(8'h04);
    expect_ev(EV_DONE, 8'h00);
    send_cmd(8'hED, 1'b1, 8'h04);
    host_frame(1'b1, 12);
    reply(8'hFA);
    host_frame(1'b1, 12);
    reply(8'hFA);
    wait_idle();

    cycles(20);
    chk("ev_queue_empty", 32'(ev_q.size()), 32'd0);
    chk("frame_queue_empty", 32'(frame_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
